fir_coef_bank_ctrl: RTL and testbench
=====================================

# fir_coef_bank_ctrl

Runtime coefficient manager for the dual-channel decimating FIR. It holds two coefficient banks: an active bank that drives the filter's shared coefficient input, and a shadow bank that is loaded from a coefficient stream. After a complete, well-formed load, the banks swap only at a datapath-signalled block boundary, so the filter never computes an output with mixed coefficient sets. It sits between the configuration path and the FIR MAC, replacing the static file-loaded coefficient memory.

## Interface
- TAP_COUNT, 121, number of coefficients per bank
- COEF_WIDTH, 16, signed coefficient width
- CNT_WIDTH, $clog2(TAP_COUNT), load counter width

- clk  in  1  single clock; all logic on posedge
- nrst  in  1  asynchronous, active-low reset
- cfg_tvalid  in  1  coefficient beat valid
- cfg_tready  out  1  coefficient beat ready
- cfg_tdata  in  COEF_WIDTH  coefficient; first beat is tap 0
- cfg_tlast  in  1  marks the final beat of a load
- cfg_abort  in  1  synchronous abort of the load in progress
- swap_ok  in  1  one-cycle pulse from the FIR at a sample-block boundary; swap allowed only here
- coef_out  out  TAP_COUNT*COEF_WIDTH  active bank, flattened; tap k at [k*COEF_WIDTH +: COEF_WIDTH]
- active_bank  out  1  index of the active bank
- busy  out  1  high in LOAD, DRAIN, ARMED
- swap_done  out  1  one-cycle pulse after a swap
- load_err  out  1  sticky malformed-load flag

## Operation
- States: IDLE, LOAD, DRAIN, ARMED. A beat is accepted when cfg_tvalid && cfg_tready.
- cfg_tready = 1 in IDLE, LOAD, DRAIN; 0 in ARMED and during reset. It is decoded from the state register only, with no combinational input-to-ready path.
- IDLE: an accepted beat writes shadow[0], sets cnt=1, and clears load_err.
  - If tlast is set and TAP_COUNT>1: load_err=1, remain in IDLE.
  - Otherwise go to LOAD (or ARMED if TAP_COUNT==1).
- LOAD: an accepted beat writes shadow[cnt] and increments cnt.
  - tlast with cnt==TAP_COUNT-1: go to ARMED.
  - tlast with cnt<TAP_COUNT-1 (short load): load_err=1, go to IDLE.
  - no tlast with cnt==TAP_COUNT-1 (long load): write the beat, then go to DRAIN.
- DRAIN: accepted beats are discarded. When a beat with tlast is accepted: load_err=1, go to IDLE.
- ARMED: wait for swap_ok. On swap_ok: toggle active_bank, pulse swap_done on the next cycle, go to IDLE.
- cfg_abort (any state except ARMED): go to IDLE, cnt=0, no swap, load_err unchanged. A beat offered in the abort cycle is not written. cfg_abort in ARMED is ignored, because the load is already complete.
- A swap_ok outside ARMED is ignored. This includes the cycle in which the final beat is accepted; that swap waits for the next swap_ok.
- The shadow bank is always the bank not selected by active_bank. After an error or abort, shadow contents are undefined and are never exposed.
- Coefficients are stored verbatim, with no arithmetic. coef_out is a mux of the registered banks selected by active_bank.

## Timing
- Reset (nrst low, asynchronous):
  - state=IDLE, cnt=0
  - both banks all-zero, so coef_out=0
  - active_bank=0, busy=0, swap_done=0, load_err=0, cfg_tready=0
- cfg_tready rises on the first clk edge after nrst deasserts.
- Load throughput: one beat per cycle. A full load takes at least TAP_COUNT cycles.
- Swap latency: swap_ok sampled high in ARMED at edge N gives active_bank and coef_out updated after edge N, busy=0 after edge N, and swap_done high for the cycle after edge N.
- cfg_tready returns to 1 in the cycle after the swap, so a new load may begin immediately.
- Reset asserted mid-load or in ARMED aborts everything and returns both banks to zero.

## Test plan
- Reset check: hold nrst low for 5 cycles. All outputs and coef_out are 0. cfg_tready is 1 one cycle after release.
- Nominal load and swap: stream 121 beats 0x0001..0x0079 with tlast on beat 121, then pulse swap_ok 3 cycles later.
  - busy=1 from the first beat until the swap.
  - active_bank goes 0→1; swap_done pulses once.
  - coef_out tap k = k+1 (tap 0=0x0001, tap 120=0x0079).
  - Reload with 0x8000..., swap, and confirm active_bank=0.
- Short load: 60 beats with tlast on beat 60, then swap_ok. Expect load_err=1, no swap, active_bank unchanged, coef_out unchanged. The next valid load clears load_err on its first beat.
- Long load: 130 beats with tlast on beat 130. All 130 beats are accepted (DRAIN), load_err=1, no swap on a later swap_ok.
- Backpressure and coincidence:
  - random cfg_tvalid gaps: counts stay correct.
  - swap_ok in the same cycle as the last beat: no swap.
  - swap_ok 10 cycles later: swap occurs.
  - cfg_tready=0 throughout ARMED.
- Abort and reset:
  - cfg_abort after 50 beats gives IDLE, busy=0, no error, and a subsequent full load works.
  - nrst pulsed low while ARMED gives banks zero, active_bank=0, and the pending swap discarded.

Source files
------------

// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered FIR coefficient store: streams a full load into the shadow bank
// and swaps it in as the active bank only at a datapath block boundary.
module fir_coef_bank_ctrl #(
    parameter int unsigned TAP_COUNT  = 121,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = $clog2(TAP_COUNT)
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            cfg_tvalid,
    output logic                            cfg_tready,
    input  logic [COEF_WIDTH-1:0]           cfg_tdata,
    input  logic                            cfg_tlast,
    input  logic                            cfg_abort,
    input  logic                            swap_ok,
    output logic [TAP_COUNT*COEF_WIDTH-1:0] coef_out,
    output logic                            active_bank,
    output logic                            busy,
    output logic                            swap_done,
    output logic                            load_err
);

    localparam int unsigned CW = (CNT_WIDTH > 0) ? CNT_WIDTH : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAP_COUNT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ARMED} state_t;

    state_t                               state;
    logic [CW-1:0]                        cnt;
    logic [TAP_COUNT-1:0][COEF_WIDTH-1:0] bank [2];
    logic                                 shadow;
    logic                                 accept;

    assign shadow   = ~active_bank;
    assign accept   = cfg_tvalid && cfg_tready;
    assign coef_out = bank[active_bank];

    // Load sequencer; busy and cfg_tready are registered alongside every state change.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            bank[0]     <= '0;
            bank[1]     <= '0;
            active_bank <= 1'b0;
            busy        <= 1'b0;
            swap_done   <= 1'b0;
            load_err    <= 1'b0;
            cfg_tready  <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_tready <= 1'b1;
                    if (cfg_abort) begin
                        cnt <= '0;
                    end else if (accept) begin
                        bank[shadow][0] <= cfg_tdata;
                        load_err        <= 1'b0;
                        if (cfg_tlast && TAP_COUNT > 1) begin
                            load_err <= 1'b1;
                            cnt      <= '0;
                        end else if (TAP_COUNT == 1) begin
                            state      <= ARMED;
                            busy       <= 1'b1;
                            cfg_tready <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            state <= LOAD;
                            busy  <= 1'b1;
                            cnt   <= CW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (accept) begin
                        bank[shadow][cnt] <= cfg_tdata;
                        if (cnt == LAST_TAP) begin
                            cnt <= '0;
                            if (cfg_tlast) begin
                                state      <= ARMED;
                                cfg_tready <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (cfg_tlast) begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (accept && cfg_tlast) begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                ARMED: begin
                    if (swap_ok) begin
                        active_bank <= ~active_bank;
                        swap_done   <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        cfg_tready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cfg_tready <= 1'b1;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Randomised load/swap scenarios for fir_coef_bank_ctrl against a load-outcome model.
module tb_fir_coef_bank_ctrl;

    localparam int unsigned TAP = 121;
    localparam int unsigned W   = 16;

    logic             clk = 1'b0;
    logic             nrst;
    logic             cfg_tvalid, cfg_tready, cfg_tlast, cfg_abort, swap_ok;
    logic [W-1:0]     cfg_tdata;
    logic [TAP*W-1:0] coef_out;
    logic             active_bank, busy, swap_done, load_err;

    always #5 clk = ~clk;

    fir_coef_bank_ctrl #(.TAP_COUNT(TAP), .COEF_WIDTH(W)) dut (
        .clk(clk), .nrst(nrst),
        .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
        .cfg_tlast(cfg_tlast), .cfg_abort(cfg_abort), .swap_ok(swap_ok),
        .coef_out(coef_out), .active_bank(active_bank), .busy(busy),
        .swap_done(swap_done), .load_err(load_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what the filter should see, plus the outcome of the last load.
    logic [W-1:0] act_coef [TAP];
    logic [W-1:0] beats [$];
    logic [W-1:0] pending [$];
    logic         exp_active, exp_err, armed;

    logic o_act, o_done, o_busy, o_rdy, o_done2;
    bit   did;

    function automatic logic [TAP*W-1:0] flat_exp();
        logic [TAP*W-1:0] f;
        for (int k = 0; k < TAP; k++) f[k*W +: W] = act_coef[k];
        return f;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < TAP; k++) act_coef[k] = '0;
        exp_active = 1'b0;
        exp_err    = 1'b0;
        armed      = 1'b0;
        pending.delete();
    endfunction

    // A load terminated by tlast is good only if it carried exactly TAP beats.
    function automatic void model_load(input int n);
        if (n == TAP) begin
            pending = beats;
            armed   = 1'b1;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    function automatic bit model_swap();
        if (!armed) return 1'b0;
        for (int k = 0; k < TAP; k++) act_coef[k] = pending[k];
        exp_active = ~exp_active;
        armed      = 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_accept();
        int t = 0;
        while (!cfg_tready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL accept_timeout: cfg_tready stayed %b, required 1", cfg_tready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: k+1, mode 1: 0x8000+k, mode 2: random
    task automatic send_load(input int n, input int mode, input bit gaps,
                             input bit with_last, input bit swap_last);
        logic [W-1:0] d;
        beats.delete();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                cfg_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            case (mode)
                0:       d = W'(i + 1);
                1:       d = W'(32'h8000 + i);
                default: d = W'($urandom);
            endcase
            cfg_tvalid = 1'b1;
            cfg_tdata  = d;
            cfg_tlast  = with_last && (i == n - 1);
            swap_ok    = swap_last && (i == n - 1);
            wait_accept();
            beats.push_back(d);
        end
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        swap_ok    = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        o_act   = active_bank;
        o_done  = swap_done;
        o_busy  = busy;
        o_rdy   = cfg_tready;
        @(negedge clk);
        o_done2 = swap_done;
    endtask

    task automatic test_reset();
        nrst = 1'b0; cfg_tvalid = 0; cfg_tdata = '0; cfg_tlast = 0; cfg_abort = 0; swap_ok = 0;
        model_reset();
        repeat (5) @(negedge clk);
        n_tests++; if (coef_out !== flat_exp()) begin n_fail++; $display("FAIL rst_coef: got %h required 0", coef_out[63:0]); end
        n_tests++; if ({active_bank, busy, swap_done, load_err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b required 0000", {active_bank, busy, swap_done, load_err}); end
        n_tests++; if (cfg_tready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", cfg_tready); end
        nrst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (cfg_tready !== 1'b1) begin n_fail++; $display("FAIL rdy_after_rst: got %b required 1", cfg_tready); end
        @(negedge clk);
    endtask

    task automatic test_nominal();
        send_load(TAP, 0, 1'b0, 1'b1, 1'b0);
        model_load(TAP);
        n_tests++; if (busy !== 1'b1 || cfg_tready !== 1'b0) begin n_fail++; $display("FAIL nom_armed: busy/rdy got %b%b required 10", busy, cfg_tready); end
        repeat (3) @(negedge clk);
        n_tests++; if (active_bank !== exp_active || swap_done !== 1'b0) begin n_fail++; $display("FAIL nom_wait: act/done got %b%b required %b0", active_bank, swap_done, exp_active); end
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active) begin n_fail++; $display("FAIL nom_active: got %b required %b", o_act, exp_active); end
        n_tests++; if (o_done !== did || o_done2 !== 1'b0) begin n_fail++; $display("FAIL nom_done: got %b%b required %b0", o_done, o_done2, did); end
        n_tests++; if (o_busy !== 1'b0 || o_rdy !== 1'b1) begin n_fail++; $display("FAIL nom_post: busy/rdy got %b%b required 01", o_busy, o_rdy); end
        n_tests++; if (coef_out !== flat_exp()) begin n_fail++; $display("FAIL nom_coef: got %h required %h", coef_out[63:0], flat_exp() & 64'hFFFF_FFFF_FFFF_FFFF); end
        send_load(TAP, 1, 1'b0, 1'b1, 1'b0);
        model_load(TAP);
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did) begin n_fail++; $display("FAIL reload_swap: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
        n_tests++; if (coef_out !== flat_exp()) begin n_fail++; $display("FAIL reload_coef: got %h", coef_out[63:0]); end
    endtask

    task automatic test_short();
        send_load(60, 2, 1'b0, 1'b1, 1'b0);
        model_load(60);
        n_tests++; if (load_err !== exp_err || busy !== 1'b0) begin n_fail++; $display("FAIL short_err: err/busy got %b%b required %b0", load_err, busy, exp_err); end
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did) begin n_fail++; $display("FAIL short_noswap: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
        n_tests++; if (coef_out !== flat_exp()) begin n_fail++; $display("FAIL short_coef: got %h", coef_out[63:0]); end
        cfg_tvalid = 1'b1; cfg_tdata = W'($urandom); cfg_tlast = 1'b0;
        wait_accept();
        cfg_tvalid = 1'b0;
        exp_err = 1'b0;
        n_tests++; if (load_err !== exp_err || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear: err/busy got %b%b required 01", load_err, busy); end
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
    endtask

    task automatic test_long();
        send_load(130, 2, 1'b0, 1'b1, 1'b0);
        model_load(130);
        n_tests++; if (beats.size() != 130) begin n_fail++; $display("FAIL long_accepted: got %0d required 130", beats.size()); end
        n_tests++; if (load_err !== exp_err || busy !== 1'b0) begin n_fail++; $display("FAIL long_err: err/busy got %b%b required %b0", load_err, busy, exp_err); end
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did || coef_out !== flat_exp()) begin n_fail++; $display("FAIL long_noswap: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
    endtask

    task automatic test_back_to_back();
        bit rdy_seen;
        send_load(TAP, 2, 1'b1, 1'b1, 1'b1);
        model_load(TAP);
        n_tests++; if (active_bank !== exp_active || swap_done !== 1'b0) begin n_fail++; $display("FAIL coinc_noswap: act/done got %b%b required %b0", active_bank, swap_done, exp_active); end
        rdy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cfg_tready !== 1'b0) rdy_seen = 1'b1;
        end
        n_tests++; if (rdy_seen) begin n_fail++; $display("FAIL armed_ready: got 1 required 0"); end
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did) begin n_fail++; $display("FAIL late_swap: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
        n_tests++; if (coef_out !== flat_exp()) begin n_fail++; $display("FAIL gap_coef: got %h", coef_out[63:0]); end
    endtask

    task automatic test_abort();
        send_load(50, 2, 1'b0, 1'b0, 1'b0);
        cfg_tvalid = 1'b1; cfg_tdata = W'($urandom); cfg_abort = 1'b1;
        @(negedge clk);
        cfg_tvalid = 1'b0; cfg_abort = 1'b0;
        n_tests++; if (busy !== 1'b0 || load_err !== exp_err || cfg_tready !== 1'b1) begin n_fail++; $display("FAIL abort_idle: busy/err/rdy got %b%b%b required 0%b1", busy, load_err, cfg_tready, exp_err); end
        send_load(TAP, 2, 1'b0, 1'b1, 1'b0);
        model_load(TAP);
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did || coef_out !== flat_exp()) begin n_fail++; $display("FAIL abort_reload: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
    endtask

    task automatic test_reset_armed();
        send_load(TAP, 2, 1'b0, 1'b1, 1'b0);
        model_load(TAP);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (coef_out !== flat_exp() || active_bank !== exp_active || busy !== 1'b0) begin n_fail++; $display("FAIL rst_armed: act/busy got %b%b required 00, coef %h", active_bank, busy, coef_out[63:0]); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_swap();
        did = model_swap();
        n_tests++; if (o_act !== exp_active || o_done !== did || coef_out !== flat_exp()) begin n_fail++; $display("FAIL rst_discard: act/done got %b%b required %b%b", o_act, o_done, exp_active, did); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_back_to_back();
        test_abort();
        test_reset_armed();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
